bonus_spawn_scheduler: RTL and testbench

- Upstream controller for the bonus ship. Decides when a bonus ship launches and drives the ship's `rise` input with a one-cycle pulse after a pseudo-random delay, counted in frames.
- Tracks the ship's lifetime through its `alive` output and the fire-collision signal. Reports each ship as killed or escaped and keeps a saturating kill count for the score logic.
- Sits between the game-control logic (playGame, startOfFrame) and the bonus ship block.

---
 rtl/bonus_spawn_scheduler.sv | 161 ++++++++++++++++
 tb/tb_bonus_spawn_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bonus_spawn_scheduler.sv
// Bonus ship launch scheduler. It pulses rise after an LFSR-randomised number of frames,
// follows the ship's lifetime, and reports each flight as killed or escaped.
module bonus_spawn_scheduler #(
  parameter int          MIN_FRAMES    = 256,
  parameter int          RANGE_BITS    = 9,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          ALIVE_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        playGame,
  input  logic        bonusShipAlive,
  input  logic        bonusFireCollision,
  output logic        rise,
  output logic        shipKilled,
  output logic        shipEscaped,
  output logic [3:0]  killCount,
  output logic [10:0] framesToSpawn
);

  localparam int          TMO_W      = (ALIVE_TIMEOUT < 1) ? 1 : $clog2(ALIVE_TIMEOUT + 1);
  localparam logic [15:0] RANGE_MASK = 16'((32'd1 << RANGE_BITS) - 32'd1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    FIRE,
    WAIT_ALIVE,
    ACTIVE,
    REPORT
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [15:0]       lfsr;
  logic [10:0]       delayValue;
  logic [10:0]       framesNext;
  logic [TMO_W-1:0]  timeoutCnt;
  logic [TMO_W-1:0]  timeoutNext;
  logic              killLatch;
  logic              killLatchNext;
  logic              timeoutEscape;
  logic              timeoutEscapeNext;
  logic [3:0]        killCountNext;
  logic              reportKill;
  logic              outputsEnabled;

  // Free-running Fibonacci LFSR; the zero check guards against a lock-up state.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == 16'd0) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign delayValue = 11'(MIN_FRAMES) + 11'(lfsr & RANGE_MASK);
  assign reportKill = killLatch | bonusFireCollision;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= IDLE;
      framesToSpawn <= 11'd0;
      timeoutCnt    <= '0;
      killLatch     <= 1'b0;
      timeoutEscape <= 1'b0;
      killCount     <= 4'd0;
    end else begin
      state         <= nextState;
      framesToSpawn <= framesNext;
      timeoutCnt    <= timeoutNext;
      killLatch     <= killLatchNext;
      timeoutEscape <= timeoutEscapeNext;
      killCount     <= killCountNext;
    end
  end

  // Leaving the game wins over every other transition, so a dropped playGame
  // cancels a countdown, a flight or a pending report alike.
  always_comb begin
    nextState         = state;
    framesNext        = framesToSpawn;
    timeoutNext       = timeoutCnt;
    killLatchNext     = killLatch;
    timeoutEscapeNext = 1'b0;
    killCountNext     = killCount;

    if ((state != IDLE) && !playGame) begin
      nextState  = IDLE;
      framesNext = 11'd0;
    end else begin
      case (state)
        IDLE: begin
          framesNext = 11'd0;
          if (playGame) begin
            nextState = ARM;
          end
        end
        ARM: begin
          framesNext = delayValue;
          nextState  = COUNT;
        end
        COUNT: begin
          if (startOfFrame) begin
            if (framesToSpawn == 11'd0) begin
              nextState = FIRE;
            end else begin
              framesNext = framesToSpawn - 11'd1;
            end
          end
        end
        FIRE: begin
          timeoutNext   = TMO_W'(ALIVE_TIMEOUT);
          killLatchNext = 1'b0;
          nextState     = WAIT_ALIVE;
        end
        WAIT_ALIVE: begin
          if (bonusShipAlive) begin
            nextState = ACTIVE;
          end else if (startOfFrame) begin
            if (timeoutCnt == '0) begin
              nextState         = ARM;
              timeoutEscapeNext = 1'b1;
            end else begin
              timeoutNext = timeoutCnt - TMO_W'(1);
            end
          end
        end
        ACTIVE: begin
          if (bonusFireCollision) begin
            killLatchNext = 1'b1;
          end
          if (!bonusShipAlive) begin
            nextState = REPORT;
          end
        end
        REPORT: begin
          if (reportKill && (killCount != 4'd15)) begin
            killCountNext = killCount + 4'd1;
          end
          nextState = ARM;
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // A failed spawn is flagged from a register so its pulse lands in the ARM cycle
  // that follows the expiring frame, never overlapping rise or a REPORT pulse.
  assign outputsEnabled = resetN & playGame;
  assign rise           = outputsEnabled & (state == FIRE);
  assign shipKilled     = outputsEnabled & (state == REPORT) & reportKill;
  assign shipEscaped    = outputsEnabled & (((state == REPORT) & ~reportKill) | timeoutEscape);

endmodule

// File: tb/tb_bonus_spawn_scheduler.sv
// Bench for bonus_spawn_scheduler: a fixed-delay instance driven by directed scenarios and a
// randomised-delay instance driven by $urandom, both checked each cycle against a reference model.
module tb_bonus_spawn_scheduler;

  localparam int          A_MIN   = 3;
  localparam int          A_RANGE = 0;
  localparam int          B_MIN   = 256;
  localparam int          B_RANGE = 9;
  localparam int          TMO     = 4;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          B_SPAWNS = 80;

  localparam int PH_OFF = 0, PH_LOAD = 1, PH_CNT = 2, PH_LAUNCH = 3, PH_AWAIT = 4, PH_FLY = 5, PH_END = 6;

  typedef struct packed {
    int phase;
    int cnt;
    int tmo;
    bit latch;
    int kills;
    bit pendEsc;
    int lfsr;
  } ModelT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetNA = 1'b0, playA = 1'b0, sofA = 1'b0, aliveA = 1'b0, collA = 1'b0;
  logic        riseA, killedA, escapedA;
  logic [3:0]  killsA;
  logic [10:0] ftsA;
  logic        resetNB = 1'b0, playB = 1'b0, sofB = 1'b0, aliveB = 1'b0, collB = 1'b0;
  logic        riseB, killedB, escapedB;
  logic [3:0]  killsB;
  logic [10:0] ftsB;

  int    total = 0;
  int    bad = 0;
  bit    checkOn = 1'b0;
  bit    sofRunA = 1'b0;
  bit    sofRunB = 1'b0;
  bit    doneB = 1'b0;
  int    spawnsB = 0;
  ModelT mA, mB;

  bonus_spawn_scheduler #(.MIN_FRAMES(A_MIN), .RANGE_BITS(A_RANGE), .LFSR_SEED(SEED), .ALIVE_TIMEOUT(TMO)) dutA (
    .clk(clk), .resetN(resetNA), .startOfFrame(sofA), .playGame(playA), .bonusShipAlive(aliveA),
    .bonusFireCollision(collA), .rise(riseA), .shipKilled(killedA), .shipEscaped(escapedA),
    .killCount(killsA), .framesToSpawn(ftsA));

  bonus_spawn_scheduler #(.MIN_FRAMES(B_MIN), .RANGE_BITS(B_RANGE), .LFSR_SEED(SEED), .ALIVE_TIMEOUT(TMO)) dutB (
    .clk(clk), .resetN(resetNB), .startOfFrame(sofB), .playGame(playB), .bonusShipAlive(aliveB),
    .bonusFireCollision(collB), .rise(riseB), .shipKilled(killedB), .shipEscaped(escapedB),
    .killCount(killsB), .framesToSpawn(ftsB));

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, actual, lo, hi, $time);
    end
  endtask

  function automatic ModelT modelReset();
    ModelT m;
    m.phase = PH_OFF; m.cnt = 0; m.tmo = 0; m.latch = 1'b0;
    m.kills = 0; m.pendEsc = 1'b0; m.lfsr = int'(SEED);
    return m;
  endfunction

  // Reference behaviour: one game-rule step per clock from the current inputs.
  function automatic ModelT modelStep(ModelT m, bit rn, bit play, bit sof, bit alive, bit coll,
                                      int minF, int rangeBits);
    ModelT n;
    int fb;
    if (!rn) return modelReset();
    n = m;
    fb = (m.lfsr ^ (m.lfsr >> 2) ^ (m.lfsr >> 3) ^ (m.lfsr >> 5)) & 1;
    n.lfsr = (m.lfsr == 0) ? int'(SEED) : ((m.lfsr >> 1) | (fb << 15));
    n.pendEsc = 1'b0;
    if (m.phase != PH_OFF && !play) begin
      n.phase = PH_OFF;
      n.cnt = 0;
      return n;
    end
    case (m.phase)
      PH_OFF:    begin n.cnt = 0; if (play) n.phase = PH_LOAD; end
      PH_LOAD:   begin n.cnt = minF + (m.lfsr % (1 << rangeBits)); n.phase = PH_CNT; end
      PH_CNT:    if (sof) begin if (m.cnt == 0) n.phase = PH_LAUNCH; else n.cnt = m.cnt - 1; end
      PH_LAUNCH: begin n.tmo = TMO; n.latch = 1'b0; n.phase = PH_AWAIT; end
      PH_AWAIT: begin
        if (alive) n.phase = PH_FLY;
        else if (sof) begin
          if (m.tmo == 0) begin n.phase = PH_LOAD; n.pendEsc = 1'b1; end
          else n.tmo = m.tmo - 1;
        end
      end
      PH_FLY:    begin if (coll) n.latch = 1'b1; if (!alive) n.phase = PH_END; end
      PH_END:    begin if (m.latch || coll) n.kills = (m.kills >= 15) ? 15 : m.kills + 1; n.phase = PH_LOAD; end
      default:   n.phase = PH_OFF;
    endcase
    return n;
  endfunction

  task automatic compareModel(input string tag, input ModelT m, input bit rn, input bit play, input bit coll,
                              input bit r, input bit k, input bit e, input int kc, input int fts);
    bit act, hit;
    act = rn && play;
    hit = m.latch || coll;
    checkOutput({tag, " rise"}, int'(r), int'(act && m.phase == PH_LAUNCH));
    checkOutput({tag, " shipKilled"}, int'(k), int'(act && m.phase == PH_END && hit));
    checkOutput({tag, " shipEscaped"}, int'(e), int'(act && ((m.phase == PH_END && !hit) || m.pendEsc)));
    checkOutput({tag, " killCount"}, kc, m.kills);
    checkOutput({tag, " framesToSpawn"}, fts, m.cnt);
  endtask

  initial begin
    mA = modelReset();
    mB = modelReset();
    forever begin
      @(posedge clk);
      mA = modelStep(mA, resetNA, playA, sofA, aliveA, collA, A_MIN, A_RANGE);
      mB = modelStep(mB, resetNB, playB, sofB, aliveB, collB, B_MIN, B_RANGE);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkOn) begin
        compareModel("A", mA, resetNA, playA, collA, riseA, killedA, escapedA, int'(killsA), int'(ftsA));
        compareModel("B", mB, resetNB, playB, collB, riseB, killedB, escapedB, int'(killsB), int'(ftsB));
        checkOutput("B lfsr nonzero", int'(dutB.lfsr != 16'd0), 1);
      end
    end
  end

  // Frame pulse generators: every 10th cycle for A, mostly-every-cycle for B.
  initial begin
    int phaseA = 0;
    forever begin
      @(posedge clk);
      #1;
      phaseA = (phaseA + 1) % 10;
      sofA = sofRunA && (phaseA == 0);
      sofB = sofRunB && ($urandom_range(0, 15) != 0);
    end
  end

  // Measures each B spawn delay in startOfFrames from the countdown load to rise.
  initial begin
    int prevFts = 0;
    int sofCount = 0;
    bit counting = 1'b0;
    forever begin
      @(negedge clk);
      if (checkOn && resetNB) begin
        if (int'(ftsB) > prevFts) begin
          counting = 1'b1;
          sofCount = 0;
        end
        if (riseB) begin
          if (counting) begin
            checkRange("B spawn delay", sofCount, B_MIN + 1, B_MIN + (1 << B_RANGE));
            spawnsB++;
          end
          counting = 1'b0;
        end else if (counting && sofB) begin
          sofCount++;
        end
        prevFts = int'(ftsB);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // which: 0 rise, 1 shipKilled, 2 shipEscaped, 3 either report pulse
  task automatic waitEvent(input int which, input int budget, output int sofs, output bit hit, output bit prevSof);
    bit ev;
    sofs = 0; hit = 1'b0; prevSof = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      case (which)
        0:       ev = riseA;
        1:       ev = killedA;
        2:       ev = escapedA;
        default: ev = killedA | escapedA;
      endcase
      if (ev) begin
        hit = 1'b1;
        break;
      end
      if (sofA) sofs++;
      prevSof = sofA;
    end
    if (!hit) checkOutput($sformatf("A wait for event %0d", which), 0, 1);
  endtask

  // mode 0: mid-flight hit, 1: clean escape, 2: hit on the cycle alive falls
  task automatic applyStimulus(input bit needRise, input int mode, output bit gotKill, output bit gotEsc);
    int s;
    bit h, p;
    gotKill = 1'b0;
    gotEsc = 1'b0;
    if (needRise) begin
      waitEvent(0, 200, s, h, p);
      if (!h) return;
    end
    nextCycle();
    aliveA = 1'b1;
    repeat (2) nextCycle();
    if (mode == 0) begin
      collA = 1'b1;
      nextCycle();
      collA = 1'b0;
    end
    repeat (20) nextCycle();
    aliveA = 1'b0;
    if (mode == 2) collA = 1'b1;
    waitEvent(3, 50, s, h, p);
    gotKill = killedA;
    gotEsc = escapedA;
    nextCycle();
    collA = 1'b0;
  endtask

  initial begin
    int  s, g;
    bit  h, p, k, e;
    int  seq[$];
    bit  seen, lastSof;
    int  rises;

    repeat (3) nextCycle();
    checkOn = 1'b1;
    checkOutput("A reset killCount", int'(killsA), 0);
    checkOutput("A reset framesToSpawn", int'(ftsA), 0);
    checkOutput("A reset rise", int'(riseA), 0);
    resetNA = 1'b1;
    resetNB = 1'b1;
    playB = 1'b1;
    sofRunB = 1'b1;
    nextCycle();

    $display("[TB] fixed delay countdown");
    playA = 1'b1;
    sofRunA = 1'b1;
    seen = 1'b0; lastSof = 1'b0; h = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (riseA) begin h = 1'b1; break; end
      if (ftsA != 11'd0) seen = 1'b1;
      if (seen && sofA) seq.push_back(int'(ftsA));
      lastSof = sofA;
    end
    checkOutput("A first rise seen", int'(h), 1);
    checkOutput("A counted frames", seq.size(), 4);
    for (int i = 0; i < seq.size() && i < 4; i++) checkOutput($sformatf("A countdown step %0d", i), seq[i], 3 - i);
    checkOutput("A rise follows frame", int'(lastSof), 1);

    $display("[TB] kill");
    applyStimulus(1'b0, 0, k, e);
    checkOutput("A kill pulse", int'(k), 1);
    checkOutput("A kill no escape", int'(e), 0);
    checkOutput("A killCount after kill", int'(killsA), 1);
    g = 0;
    while (ftsA == 11'd0 && g < 20) begin @(negedge clk); g++; end
    checkOutput("A next countdown start", int'(ftsA), 3);

    $display("[TB] escape and simultaneous hit");
    applyStimulus(1'b1, 1, k, e);
    checkOutput("A escape pulse", int'(e), 1);
    checkOutput("A escape no kill", int'(k), 0);
    checkOutput("A killCount after escape", int'(killsA), 1);
    applyStimulus(1'b1, 2, k, e);
    checkOutput("A same-cycle hit kill", int'(k), 1);
    checkOutput("A killCount after same-cycle hit", int'(killsA), 2);

    $display("[TB] spawn timeout");
    waitEvent(0, 200, s, h, p);
    waitEvent(2, 200, s, h, p);
    checkOutput("A timeout frames", s, TMO + 1);
    checkOutput("A timeout escape after frame", int'(p), 1);
    waitEvent(0, 200, s, h, p);
    checkOutput("A rise after timeout", int'(h), 1);

    $display("[TB] abort mid-countdown");
    g = 0;
    while (ftsA == 11'd0 && g < 200) begin @(negedge clk); g++; end
    checkOutput("A in countdown before abort", int'(ftsA != 11'd0), 1);
    nextCycle();
    playA = 1'b0;
    nextCycle();
    checkOutput("A framesToSpawn after abort", int'(ftsA), 0);
    rises = 0;
    repeat (60) begin @(negedge clk); if (riseA) rises++; end
    checkOutput("A no rise while stopped", rises, 0);
    nextCycle();
    playA = 1'b1;

    $display("[TB] kill count saturation");
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 0, k, e);
    checkOutput("A killCount saturated", int'(killsA), 15);

    $display("[TB] reset mid-flight");
    waitEvent(0, 200, s, h, p);
    nextCycle();
    aliveA = 1'b1;
    repeat (4) nextCycle();
    resetNA = 1'b0;
    nextCycle();
    resetNA = 1'b1;
    aliveA = 1'b0;
    checkOutput("A killCount after reset", int'(killsA), 0);
    checkOutput("A framesToSpawn after reset", int'(ftsA), 0);
    checkOutput("A rise after reset", int'(riseA), 0);
    checkOutput("A shipKilled after reset", int'(killedA), 0);
    checkOutput("A shipEscaped after reset", int'(escapedA), 0);
    playA = 1'b0;
    sofRunA = 1'b0;

    g = 0;
    while (!doneB && g < 90000) begin nextCycle(); g++; end
    checkOutput("B random run completed", int'(doneB), 1);
    checkOutput("B spawns measured", int'(spawnsB >= B_SPAWNS), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Randomised ship behaviour for B: late or missing alive, random hits, random hit on the fall.
  initial begin
    int g;
    int n;
    @(posedge clk);
    wait (checkOn);
    while (spawnsB < B_SPAWNS) begin
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!riseB && g < 2000);
      if (!riseB) begin
        checkOutput("B rise within budget", 0, 1);
        break;
      end
      nextCycle();
      repeat ($urandom_range(0, 6)) nextCycle();
      aliveB = 1'b1;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        collB = ($urandom_range(0, 3) == 0);
        nextCycle();
      end
      aliveB = 1'b0;
      collB = ($urandom_range(0, 1) == 1);
      nextCycle();
      collB = 1'b0;
    end
    doneB = 1'b1;
  end

endmodule
